pipelined_carry_lookahead_adder: RTL and testbench
==================================================

PIPELINED_CARRY_LOOKAHEAD_ADDER -- requirements
Module: pipelined_carry_lookahead_adder

Interface
REQ-001 The block SHALL have parameter GROUP_WIDTH, default 4: bits per lookahead group (>=1).
REQ-002 The block SHALL have parameter GROUP_COUNT, default 2: number of groups, and also the number of pipeline stages (>=1).
REQ-003 The block SHALL derive local WIDTH = GROUP_WIDTH*GROUP_COUNT; it SHALL NOT be overridable.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the operand set is presented.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts the operand set this cycle.
REQ-008 The block SHALL have ports x and y, input, WIDTH bits each: the operands.
REQ-009 The block SHALL have port carry_in, input, 1 bit: carry into bit 0 (add mode only).
REQ-010 The block SHALL have port sub, input, 1 bit: 1 = subtract (x - y), 0 = add.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the result is presented.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 The block SHALL have port z, output, WIDTH bits: the sum or difference.
REQ-014 The block SHALL have port carry_out, output, 1 bit: carry out of the MSB.
REQ-015 The block SHALL have port overflow, output, 1 bit: two's-complement signed overflow.

Function
REQ-016 A transfer SHALL occur on any cycle with in_valid & in_ready; an output transfer SHALL occur on any cycle with out_valid & out_ready.
REQ-017 Operand mapping SHALL be: effective operand = sub ? ~y : y; effective carry = sub ? 1 : carry_in.
- In subtract mode, carry_in SHALL be ignored.
REQ-018 Stage k (k = 0..GROUP_COUNT-1) SHALL add group k, i.e. bits [k*GROUP_WIDTH +: GROUP_WIDTH], using in-group generate/propagate lookahead.
- The group carry-out SHALL be registered into stage k+1.
- The carry SHALL NOT ripple across more than one group in any cycle.
REQ-019 Skew alignment:
- Operand groups above stage k SHALL be carried forward with their own transaction.
- Completed lower result groups SHALL be delayed, so z is assembled entirely from one transaction.
REQ-020 Latency SHALL be exactly GROUP_COUNT cycles from an input transfer to out_valid, when no stall occurs.
REQ-021 Throughput SHALL be one transaction per cycle when out_ready is held at 1.
REQ-022 Each stage SHALL carry a valid bit.
- The pipeline SHALL advance as a whole when en = ~out_valid | out_ready.
- When en = 0, every stage SHALL hold.
- Bubbles SHALL NOT be collapsed.
REQ-023 in_ready SHALL equal en & ~reset (combinational).
REQ-024 While out_valid = 1 and out_ready = 0, z, carry_out and overflow SHALL remain stable.
REQ-025 Transactions SHALL leave the block in acceptance order, and none SHALL be dropped or duplicated.
REQ-026 overflow SHALL equal (carry into the MSB) XOR carry_out, computed for the same transaction.
REQ-027 After a transfer, z, carry_out and overflow SHALL hold their last values while out_valid = 0.
REQ-028 With GROUP_COUNT = 1, the block SHALL be a single registered stage with latency 1.

Reset
REQ-029 While reset = 1 at a rising edge, the block SHALL clear all stage valid bits.
- It SHALL set out_valid = 0, z = 0, carry_out = 0 and overflow = 0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight transactions; none SHALL appear after reset deasserts.
REQ-031 in_ready SHALL be 0 while reset = 1, and 1 on the first cycle after reset deasserts.

Verification (defaults: WIDTH = 8, latency 2)
REQ-032 Signed overflow: add x=0x7F, y=0x01, carry_in=0 -> 2 cycles later z=0x80, carry_out=0, overflow=1.
REQ-033 Wrap-around: add x=0xFF, y=0x01, carry_in=0 -> z=0x00, carry_out=1, overflow=0.
REQ-034 Carry across the group boundary: add x=0x0F, y=0x01, carry_in=1 -> z=0x11, carry_out=0.
REQ-035 Subtract: sub=1, x=0x05, y=0x07, carry_in=1 -> z=0xFE, carry_out=0, overflow=0 (carry_in ignored).
REQ-036 Backpressure:
- Stimulus: issue 3 back-to-back adds (1+1, 2+2, 3+3), hold out_ready=0 for 3 cycles, then release.
- Response: in_ready=0 while stalled; z=0x02 held stable; results 0x02, 0x04, 0x06 delivered in order with none lost.
REQ-037 Reset mid-operation:
- Stimulus: 2 transactions in flight, reset=1 for 1 cycle.
- Response: out_valid=0 and z=0 the next cycle; neither result is ever presented.

Source files
------------

// File: rtl/pipelined_carry_lookahead_adder.sv
// Pipelined adder/subtractor: one lookahead group per stage, group carry registered between stages.
// Upper operand groups travel with their transaction and finished low groups are delayed, so z is never mixed.
module pipelined_carry_lookahead_adder #(
    parameter int unsigned GROUP_WIDTH = 4,
    parameter int unsigned GROUP_COUNT = 2,
    localparam int unsigned WIDTH = GROUP_WIDTH * GROUP_COUNT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned GW   = GROUP_WIDTH;
    localparam int          LAST = int'(GROUP_COUNT) - 1;

    // Returns {carry into group MSB, group carry out, group sum}; carries are flat sum-of-products.
    function automatic logic [GROUP_WIDTH+1:0] group_add(
        input logic [GROUP_WIDTH-1:0] a,
        input logic [GROUP_WIDTH-1:0] b,
        input logic                   cin
    );
        logic [GROUP_WIDTH-1:0] g;
        logic [GROUP_WIDTH-1:0] p;
        logic [GROUP_WIDTH:0]   c;
        logic                   term;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(GW); i++) begin
            term = cin;
            for (int j = 0; j <= i; j++) term &= p[j];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) term &= p[m];
                c[i+1] |= term;
            end
        end
        return {c[GW-1], c[GW], p ^ c[GW-1:0]};
    endfunction

    logic                   en;

    logic                   src_v  [GROUP_COUNT];
    logic [WIDTH-1:0]       src_a  [GROUP_COUNT];
    logic [WIDTH-1:0]       src_b  [GROUP_COUNT];
    logic [WIDTH-1:0]       src_s  [GROUP_COUNT];
    logic                   src_c  [GROUP_COUNT];

    logic [GROUP_WIDTH+1:0] res    [GROUP_COUNT];
    logic [WIDTH-1:0]       nxt_s  [GROUP_COUNT];
    logic                   nxt_c  [GROUP_COUNT];
    logic                   nxt_ov [GROUP_COUNT];

    logic                   v_q    [GROUP_COUNT];
    logic [WIDTH-1:0]       a_q    [GROUP_COUNT];
    logic [WIDTH-1:0]       b_q    [GROUP_COUNT];
    logic [WIDTH-1:0]       s_q    [GROUP_COUNT];
    logic                   c_q    [GROUP_COUNT];
    logic                   ov_q;

    assign en        = ~out_valid | out_ready;
    assign in_ready  = en & ~reset;
    assign out_valid = v_q[LAST];
    assign z         = s_q[LAST];
    assign carry_out = c_q[LAST];
    assign overflow  = ov_q;

    // Stage sources (stage 0 from the ports) and the per-stage group addition.
    always_comb begin
        src_v[0] = in_valid;
        src_a[0] = x;
        src_b[0] = sub ? ~y : y;
        src_c[0] = sub | carry_in;
        src_s[0] = '0;
        for (int k = 1; k < int'(GROUP_COUNT); k++) begin
            src_v[k] = v_q[k-1];
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = s_q[k-1];
            src_c[k] = c_q[k-1];
        end
        for (int k = 0; k < int'(GROUP_COUNT); k++) begin
            res[k]                  = group_add(src_a[k][k*GW +: GW], src_b[k][k*GW +: GW], src_c[k]);
            nxt_s[k]                = src_s[k];
            nxt_s[k][k*GW +: GW]    = res[k][GW-1:0];
            nxt_c[k]                = res[k][GW];
            nxt_ov[k]               = res[k][GW+1] ^ res[k][GW];
        end
    end

    // Whole pipeline advances on en; the output stage only loads real transactions.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < int'(GROUP_COUNT); k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
            ov_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < int'(GROUP_COUNT); k++) begin
                v_q[k] <= src_v[k];
                if (k != LAST || src_v[k]) begin
                    a_q[k] <= src_a[k];
                    b_q[k] <= src_b[k];
                    s_q[k] <= nxt_s[k];
                    c_q[k] <= nxt_c[k];
                end
            end
            if (src_v[LAST]) ov_q <= nxt_ov[LAST];
        end
    end

endmodule

// File: tb/tb_pipelined_carry_lookahead_adder.sv
// Scoreboard bench for the pipelined adder: directed vectors, stall and mid-flight reset.
module tb_pipelined_carry_lookahead_adder;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] x = '0;
    logic [7:0] y = '0;
    logic       carry_in = 1'b0;
    logic       sub = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] z;
    logic       carry_out;
    logic       overflow;

    typedef struct {
        logic [7:0] z;
        logic       co;
        logic       ov;
        int         cyc;
        bit         lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    pipelined_carry_lookahead_adder dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .carry_in  (carry_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every output transfer.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got z=0x%0h, expected no output", z);
            end else begin
                mon_e = sb.pop_front();
                check("z", 32'(z), 32'(mon_e.z));
                check("carry_out", 32'(carry_out), 32'(mon_e.co));
                check("overflow", 32'(overflow), 32'(mon_e.ov));
                if (mon_e.lat) check("latency", 32'(cyc - mon_e.cyc), 32'd2);
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic s,
                        input logic [7:0] ez, input logic eco, input logic eov,
                        input bit push, input bit lat);
        int n;
        bit acc;
        exp_t e;
        n = 0;
        acc = 1'b0;
        x = a;
        y = b;
        carry_in = ci;
        sub = s;
        in_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clock);
            acc = in_ready;
            if (acc && push) begin
                e.z = ez; e.co = eco; e.ov = eov; e.cyc = cyc; e.lat = lat;
                sb.push_back(e);
            end
            @(posedge clock);
            #1;
            n++;
        end
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clock);
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_z", 32'(z), 32'd0);
        check("rst_carry_out", 32'(carry_out), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clock); #1;

        // Back-to-back directed vectors with latency check
        send(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1, 1);
        send(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1, 1);
        send(8'h0F, 8'h01, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1, 1);
        send(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1, 1);
        send(8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1, 1);
        send(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1, 1);
        send(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1, 1);
        send(8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1, 1);
        send(8'h08, 8'h08, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1, 1);
        drain();
        repeat (2) @(posedge clock);
        #1;
        check("hold_out_valid", 32'(out_valid), 32'd0);
        check("hold_z", 32'(z), 32'h10);
        check("hold_carry_out", 32'(carry_out), 32'd0);

        // Backpressure
        out_ready = 1'b0;
        fork
            begin
                send(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1, 0);
                send(8'h02, 8'h02, 1'b0, 1'b0, 8'h04, 1'b0, 1'b0, 1, 0);
                send(8'h03, 8'h03, 1'b0, 1'b0, 8'h06, 1'b0, 1'b0, 1, 0);
            end
            begin
                n = 0;
                @(negedge clock);
                while (!out_valid && n < 20) begin
                    @(negedge clock);
                    n++;
                end
                for (int i = 0; i < 3; i++) begin
                    check("stall_out_valid", 32'(out_valid), 32'd1);
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                    check("stall_z", 32'(z), 32'h02);
                    if (i < 2) @(negedge clock);
                end
                @(posedge clock); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two transactions in flight
        @(posedge clock); #1;
        out_ready = 1'b0;
        send(8'h11, 8'h22, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 0, 0);
        send(8'h21, 8'h10, 1'b0, 1'b0, 8'h31, 1'b0, 1'b0, 0, 0);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_z", 32'(z), 32'd0);
        check("midrst_carry_out", 32'(carry_out), 32'd0);
        check("midrst_in_ready_after", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (out_valid) seen++;
        end
        check("midrst_no_ghost", 32'(seen), 32'd0);

        // Recovery after reset
        @(posedge clock); #1;
        send(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
